// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage.
//   ADDR_W / INSTR_W : byte-address and instruction widths
//   NOP              : addi x0,x0,0, shown on o_instr when no valid instruction
//   fetch_state_e    : FETCH_RUN / FETCH_HALT
package fetch_stage_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

  typedef enum logic {
    FETCH_RUN  = 1'b0,
    FETCH_HALT = 1'b1
  } fetch_state_e;

  // Instructions are word aligned; any set low bit is a bad target.
  function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_pc_next.sv
// Combinational next-request-address mux and redirect alignment check.
//   rst_i            : reset in progress, request the reset PC
//   halted_i         : FSM is in HALT, freeze the PC
//   primed_i         : memory holds the word at pc_i (low only in the first
//                      cycle after reset)
//   halt_i           : halt request this cycle
//   redirect_i       : taken branch/jump this cycle
//   redirect_addr_i  : redirect target
//   stall_i          : decode stall, re-read current word
//   pc_i             : PC of the instruction currently on the memory output
//   reset_pc_i       : reset address
//   next_addr_o      : address to present to instruction memory
//   misaligned_o     : accepted redirect whose target is not word aligned
module fetch_pc_next
  import fetch_stage_pkg::*;
(
  input  logic              rst_i,
  input  logic              halted_i,
  input  logic              primed_i,
  input  logic              halt_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_addr_i,
  input  logic              stall_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [ADDR_W-1:0] reset_pc_i,
  output logic [ADDR_W-1:0] next_addr_o,
  output logic              misaligned_o
);

  always_comb begin
    // A halt in the same cycle wins, so the redirect is not even checked.
    misaligned_o = redirect_i && !halt_i && !halted_i && is_misaligned(redirect_addr_i);
    next_addr_o  = pc_i + ADDR_W'(4);
    if (rst_i) begin
      next_addr_o = reset_pc_i;
    end else if (halted_i || halt_i || misaligned_o) begin
      // Entering or sitting in HALT: never request the bad/ignored target.
      next_addr_o = pc_i;
    end else if (redirect_i) begin
      next_addr_o = redirect_addr_i;
    end else if (stall_i || !primed_i) begin
      // Re-read the same word so the memory output holds steady.
      next_addr_o = pc_i;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage. Owns the PC, drives a one-cycle registered
// instruction memory, and hands {instr, pc, valid} to decode.
//   clk, rst          : clock, synchronous active-high reset
//   i_stall           : decode cannot accept; hold outputs
//   i_redirect(_addr) : taken branch/jump and its target
//   i_halt            : stop fetching until reset
//   o_req_addr        : memory request address (combinational)
//   i_res_data        : memory data for the previous request
//   o_instr/o_pc      : instruction to decode and its PC
//   o_valid           : o_instr is real
//   o_fault           : sticky misaligned-redirect flag
//   o_fetch_count     : saturating count of instructions accepted by decode
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_stall,
  input  logic               i_redirect,
  input  logic [ADDR_W-1:0]  i_redirect_addr,
  input  logic               i_halt,
  output logic [ADDR_W-1:0]  o_req_addr,
  input  logic [INSTR_W-1:0] i_res_data,
  output logic [INSTR_W-1:0] o_instr,
  output logic [ADDR_W-1:0]  o_pc,
  output logic               o_valid,
  output logic               o_fault,
  output logic [31:0]        o_fetch_count
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] r_pc_q;
  logic              r_valid_q;
  logic              fault_q, fault_d;
  logic [31:0]       count_q, count_d;
  logic              misaligned;

  fetch_pc_next u_pc_next (
    .rst_i          (rst),
    .halted_i       (state_q == FETCH_HALT),
    .primed_i       (r_valid_q),
    .halt_i         (i_halt),
    .redirect_i     (i_redirect),
    .redirect_addr_i(i_redirect_addr),
    .stall_i        (i_stall),
    .pc_i           (r_pc_q),
    .reset_pc_i     (RESET_PC),
    .next_addr_o    (o_req_addr),
    .misaligned_o   (misaligned)
  );

  assign o_pc          = r_pc_q;
  assign o_valid       = r_valid_q && (state_q == FETCH_RUN);
  assign o_instr       = o_valid ? i_res_data : NOP;
  assign o_fault       = fault_q;
  assign o_fetch_count = count_q;

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    count_d = count_q;
    case (state_q)
      FETCH_RUN: begin
        if (i_halt || misaligned) state_d = FETCH_HALT;
        if (misaligned)           fault_d = 1'b1;
      end
      FETCH_HALT: ;  // only reset leaves HALT
      default:    state_d = FETCH_RUN;
    endcase
    // A redirect-cycle instruction is squashed downstream, so it is not counted.
    if (o_valid && !i_stall && !i_redirect && (count_q != '1))
      count_d = count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH_RUN;
      r_pc_q    <= RESET_PC;
      r_valid_q <= 1'b0;
      fault_q   <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      r_pc_q    <= o_req_addr;
      // Memory data lines up with r_pc from here on.
      r_valid_q <= 1'b1;
      fault_q   <= fault_d;
      count_q   <= count_d;
    end
  end

endmodule
